// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code-set-2 decoder: folds E0/F0/E1 prefix sequences into key events, buffered in a FWFT FIFO.
// Optional `TYPEMATIC_FILTER_EN suppresses repeated makes of the currently held key.
module ps2_scan_decoder #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] din,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, PAUSE} state_t;

  state_t        state;
  logic          ext_flag;
  logic [2:0]    pause_cnt;
  logic [TW-1:0] tmo_cnt;

  logic       is_status;
  logic       emit;
  logic       emit_brk;
  logic       emit_ext;
  logic [7:0] emit_code;
  logic       suppress;

  always_comb begin
    is_status = 1'b0;
    case (din)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_status = 1'b1;
      default: is_status = 1'b0;
    endcase
  end

  // Event produced by the byte arriving this cycle; written to the FIFO at the same edge.
  always_comb begin
    emit      = 1'b0;
    emit_brk  = 1'b0;
    emit_ext  = 1'b0;
    emit_code = din;
    if (rx_done_tick) begin
      unique case (state)
        IDLE:  emit = !is_status && din != 8'hE0 && din != 8'hF0 && din != 8'hE1;
        EXT: begin
          emit     = din != 8'hF0 && din != 8'hE0;
          emit_ext = 1'b1;
        end
        BRK: begin
          emit     = din != 8'hF0 && din != 8'hE0;
          emit_brk = 1'b1;
          emit_ext = ext_flag;
        end
        PAUSE: begin
          emit      = pause_cnt == 3'd1;
          emit_code = 8'hE1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ext_flag  <= 1'b0;
      pause_cnt <= '0;
      tmo_cnt   <= '0;
    end else if (rx_done_tick) begin
      tmo_cnt <= '0;
      unique case (state)
        IDLE: begin
          if (din == 8'hE0) begin
            state <= EXT;
          end else if (din == 8'hF0) begin
            state    <= BRK;
            ext_flag <= 1'b0;
          end else if (din == 8'hE1) begin
            state     <= PAUSE;
            pause_cnt <= 3'd7;
          end
        end
        EXT: begin
          if (din == 8'hF0) begin
            state    <= BRK;
            ext_flag <= 1'b1;
          end else if (din != 8'hE0) begin
            state <= IDLE;
          end
        end
        BRK: begin
          if (din != 8'hF0 && din != 8'hE0) state <= IDLE;
        end
        PAUSE: begin
          pause_cnt <= pause_cnt - 3'd1;
          if (pause_cnt == 3'd1) state <= IDLE;
        end
      endcase
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  logic       held;
  logic [8:0] held_key;

  assign suppress = emit && !emit_brk && held && (held_key == {emit_ext, emit_code});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held     <= 1'b0;
      held_key <= '0;
    end else if (emit) begin
      if (!emit_brk) begin
        held     <= 1'b1;
        held_key <= {emit_ext, emit_code};
      end else if (held && held_key == {emit_ext, emit_code}) begin
        held <= 1'b0;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push;

  assign full     = count == (AW + 1)'(FIFO_DEPTH);
  assign pop      = key_valid && key_ready;
  assign push_req = emit && !suppress;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req && full && !pop;
      if (push) begin
        mem[wr_ptr] <= {emit_code, emit_brk, emit_ext};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign key_valid = count != '0;
  assign key_code  = mem[rd_ptr][9:2];
  assign key_break = mem[rd_ptr][1];
  assign key_ext   = mem[rd_ptr][0];

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: directed vector table, corner sequences, and random bytes vs a queue model.
module tb_ps2_scan_decoder;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] din = 8'h00;
  logic       key_ready = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic       overflow;

  ps2_scan_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .din(din),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_break(key_break), .key_ext(key_ext), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ev_t;

  typedef struct {
    logic       t;
    logic [7:0] d;
    logic       v;
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } vec_t;

  int checks = 0;
  int failures = 0;

  ev_t          q[$];
  logic [7:0]   pend[$];
  int unsigned  since;
  logic         exp_ovf;
`ifdef TYPEMATIC_FILTER_EN
  logic         m_held;
  logic [8:0]   m_key;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_status(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

  function automatic void model_reset();
    q.delete();
    pend.delete();
    since   = 0;
    exp_ovf = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
    m_held = 1'b0;
    m_key  = '0;
`endif
  endfunction

  // Byte-sequence view: pend holds the prefix bytes of the unfinished sequence.
  function automatic void model_edge(input logic t, input logic [7:0] d, input logic r);
    bit  em;
    bit  pop;
    bit  supp;
    ev_t e;
    em   = 0;
    supp = 0;
    e    = '0;
    pop  = (q.size() > 0) && r;
    if (t) begin
      since = 0;
      if (pend.size() == 0) begin
        if (d == 8'hE0 || d == 8'hF0 || d == 8'hE1) pend.push_back(d);
        else if (!is_status(d)) begin
          em = 1;
          e  = '{d, 1'b0, 1'b0};
        end
      end else if (pend[0] == 8'hE1) begin
        pend.push_back(d);
        if (pend.size() == 8) begin
          em = 1;
          e  = '{8'hE1, 1'b0, 1'b0};
          pend.delete();
        end
      end else if (d == 8'hE0 || d == 8'hF0) begin
        pend.push_back(d);
      end else begin
        em     = 1;
        e.code = d;
        e.ext  = (pend[0] == 8'hE0);
        e.brk  = 1'b0;
        foreach (pend[k]) if (pend[k] == 8'hF0) e.brk = 1'b1;
        pend.delete();
      end
    end else if (pend.size() != 0) begin
      since++;
      if (since >= TMO) begin
        pend.delete();
        since = 0;
      end
    end
`ifdef TYPEMATIC_FILTER_EN
    if (em) begin
      if (!e.brk && m_held && m_key == {e.ext, e.code}) supp = 1;
      if (!e.brk) begin
        m_held = 1'b1;
        m_key  = {e.ext, e.code};
      end else if (m_held && m_key == {e.ext, e.code}) begin
        m_held = 1'b0;
      end
    end
`endif
    if (pop) void'(q.pop_front());
    exp_ovf = 1'b0;
    if (em && !supp) begin
      if (q.size() < DEPTH) q.push_back(e);
      else exp_ovf = 1'b1;
    end
  endfunction

  task automatic check_model();
    chk("valid", {31'd0, key_valid}, {31'd0, q.size() > 0});
    if (key_valid && q.size() > 0) chk("head", {22'd0, key_code, key_break, key_ext}, {22'd0, q[0]});
    chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  task automatic cycle(input logic t, input logic [7:0] d, input logic r);
    rx_done_tick = t;
    din          = d;
    key_ready    = r;
    @(posedge clk);
    model_edge(t, d, r);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    #2;
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    key_ready    = 1'b0;
    #1;
    model_reset();
    chk("reset_outputs", {20'd0, key_valid, key_code, key_break, key_ext, overflow}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t       tbl[20];
  logic [7:0] burst[5];
  logic [7:0] tm[6];
  logic [7:0] st[7];
  int         n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h1C, 1'b1, 8'h1C, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 8'hE0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'h75, 1'b1, 8'h75, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 8'hE0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h75, 1'b1, 8'h75, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 8'hE1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 8'hE1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 8'h77, 1'b1, 8'hE1, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 8'hFA, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    burst = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    tm    = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
    st    = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

    do_reset();

    foreach (tbl[i]) begin
      cycle(tbl[i].t, tbl[i].d, 1'b1);
      chk($sformatf("tbl%0d_valid", i), {31'd0, key_valid}, {31'd0, tbl[i].v});
      if (tbl[i].v)
        chk($sformatf("tbl%0d_event", i), {22'd0, key_code, key_break, key_ext},
            {22'd0, tbl[i].code, tbl[i].brk, tbl[i].ext});
    end

    // Overflow on the fifth make with a stalled consumer, then in-order drain.
    do_reset();
    foreach (burst[i]) cycle(1'b1, burst[i], 1'b0);
    chk("ovf_pulse", {31'd0, overflow}, 32'd1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("ovf_single", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_code", {24'd0, key_code}, {24'd0, burst[i]});
      cycle(1'b0, 8'h00, 1'b1);
    end
    chk("drain_empty", {31'd0, key_valid}, 32'd0);

    // Full FIFO with simultaneous pop and push: accepted, no overflow.
    for (int i = 0; i < 4; i++) cycle(1'b1, burst[i], 1'b0);
    cycle(1'b1, 8'h33, 1'b1);
    chk("full_pushpop_ovf", {31'd0, overflow}, 32'd0);
    chk("full_pushpop_head", {24'd0, key_code}, 32'h1D);
    repeat (5) cycle(1'b0, 8'h00, 1'b1);

    // Timeout boundary: a byte on the last allowed cycle keeps E0, one later does not.
    cycle(1'b1, 8'hE0, 1'b1);
    repeat (TMO - 1) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h75, 1'b1);
    chk("tmo_edge_ext", {22'd0, key_valid, key_code, key_ext}, {22'd0, 1'b1, 8'h75, 1'b1});
    cycle(1'b1, 8'hE0, 1'b1);
    repeat (TMO) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h1C, 1'b1);
    chk("tmo_expired", {22'd0, key_valid, key_code, key_ext}, {22'd0, 1'b1, 8'h1C, 1'b0});

    // Reset between F0 and its code, and reset with buffered events.
    cycle(1'b1, 8'hF0, 1'b1);
    do_reset();
    cycle(1'b1, 8'h1C, 1'b1);
    chk("rst_mid_make", {22'd0, key_valid, key_code, key_break}, {22'd0, 1'b1, 8'h1C, 1'b0});
    cycle(1'b1, 8'h15, 1'b0);
    cycle(1'b1, 8'h1D, 1'b0);
    do_reset();

    n = 0;
    foreach (tm[i]) begin
      cycle(1'b1, tm[i], 1'b1);
      if (key_valid) n++;
    end
    cycle(1'b0, 8'h00, 1'b1);
    if (key_valid) n++;
`ifdef TYPEMATIC_FILTER_EN
    chk("typematic_events", n, 32'd3);
`else
    chk("typematic_events", n, 32'd5);
`endif

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic       t;
      logic       r;
      logic [7:0] d;
      int unsigned sel;
      r   = $urandom_range(0, 99) < 70;
      t   = $urandom_range(0, 99) < 35;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    d = 8'hE0;
        2:       d = 8'hF0;
        3:       d = 8'hE1;
        4:       d = st[$urandom_range(0, 6)];
        default: d = 8'($urandom);
      endcase
      if (i % 500 == 250) repeat (TMO + $urandom_range(0, 3) - 2) cycle(1'b0, 8'h00, r);
      if (i % 1000 == 999) do_reset();
      cycle(t, d, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
